red_pitaya_asg_seq: RTL
=======================

RED_PITAYA_ASG_SEQ -- requirements
Module: red_pitaya_asg_seq

Interface
REQ-001 Parameters, one per line: RSZ, 14, buffer address width; NSEG, 8, segment table depth (power of 2); ACT_TO, 16, activation timeout in clocks.
REQ-002 dac_clk_i  in  1  clock; one clock domain only.
REQ-003 dac_rstn_i  in  1  reset; synchronous, active-low.
REQ-004 seg_we_i  in  1  segment table write strobe.
REQ-005 seg_addr_i  in  log2(NSEG)  segment table write index.
REQ-006 seg_ofs_i  in  RSZ  segment start address.
REQ-007 seg_size_i  in  RSZ  segment end address.
REQ-008 seg_ncyc_i  in  16  table cycles per segment.
REQ-009 seg_dly_i  in  32  idle clocks after the segment.
REQ-010 seq_start_i  in  1  start pulse.
REQ-011 seq_stop_i  in  1  abort pulse.
REQ-012 seq_len_i  in  log2(NSEG)+1  segments per pass; valid range 1..NSEG.
REQ-013 seq_loop_i  in  1  repeat passes until stopped.
REQ-014 ch_act_i  in  1  channel burst-active flag (channel cycle-mode flag).
REQ-015 ch_ofs_o  out  RSZ+16  channel set_ofs; {seg_ofs,16'h0}.
REQ-016 ch_size_o  out  RSZ+16  channel set_size; {seg_size,16'h0}.
REQ-017 ch_ncyc_o  out  16  channel set_ncyc.
REQ-018 ch_rst_o  out  1  channel set_rst.
REQ-019 ch_trig_o  out  1  software trigger pulse to the channel (trigger source 1).
REQ-020 seq_busy_o  out  1  high in every state except IDLE.
REQ-021 seq_seg_o  out  log2(NSEG)  index of the current segment.
REQ-022 seq_done_o  out  1  one-clock pulse when a non-loop pass completes.
REQ-023 seq_err_o  out  1  sticky error flag.

Function
REQ-024 The FSM SHALL have the states IDLE, LOAD, TRIG, WAIT_ACT, RUN and DLY.
REQ-025 IDLE: ch_rst_o=1; on seq_start_i with 1<=seq_len_i<=NSEG, seg=0, err cleared, next state LOAD; with an invalid seq_len_i, seq_err_o=1 and the FSM stays in IDLE.
REQ-026 On the edge entering LOAD, ch_ofs_o, ch_size_o and ch_ncyc_o SHALL register table[seg] as it was before that edge (a same-edge write is not visible); ch_ncyc_o=1 if the stored ncyc is 0; ch_rst_o=1 in LOAD; LOAD lasts exactly 1 clock, then TRIG.
REQ-027 TRIG: ch_rst_o=0, ch_trig_o=1 for exactly 1 clock, then WAIT_ACT.
REQ-028 WAIT_ACT: on ch_act_i=1, go to RUN; if ch_act_i is not seen within ACT_TO clocks, set seq_err_o=1 and go to IDLE (no done pulse).
REQ-029 RUN: on ch_act_i=0, load the delay counter with seg_dly of the current segment, then go to DLY.
REQ-030 DLY: decrement once per clock, so DLY lasts max(dly,1) clocks; when the count reaches 0, advance.
REQ-031 Advance: if seg<seq_len-1, seg+1 then LOAD; else if seq_loop_i, seg=0 then LOAD; else seq_done_o=1 for 1 clock and go to IDLE. seq_loop_i is sampled at the advance.
REQ-032 seq_stop_i in any non-IDLE state SHALL force IDLE on the next edge, with ch_rst_o=1 and no done pulse; stop has priority over start and over every other transition in the same cycle.
REQ-033 seq_start_i outside IDLE is ignored; seq_len_i is captured at start.
REQ-034 Table writes are accepted in every state and take effect at the next LOAD of that index.
REQ-035 Latency from seq_start_i to ch_trig_o SHALL be 2 clocks (IDLE->LOAD->TRIG).
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 When dac_rstn_i=0 at an edge: state IDLE; ch_rst_o=1; every other output, the table, the counters and seq_err_o are 0; reset mid-run aborts immediately.

Structure
REQ-038 A shared package asg_seq_pkg SHALL hold the state encoding, the NSEG and ACT_TO defaults, and the segment record type {ofs, size, ncyc, dly}.
REQ-039 One sub-module, red_pitaya_asg_seq_tbl, SHALL implement the register-file segment table: one write port and one combinational read port indexed by seg.

Verification
REQ-040 Table seg0={ofs 0, size 0xFF, ncyc 2, dly 10}, len=1, no loop, start; channel model raises ch_act_i 2 clocks after trig and drops it 500 clocks later -> ch_trig_o 2 clocks after start, ch_ofs_o=0, ch_size_o=0xFF0000, seq_done_o exactly 10 clocks after ch_act_i falls.
REQ-041 len=3, loop=1, segments ncyc 1/2/3 -> ch_ncyc_o sequence 1,2,3,1,2,3; seq_seg_o wraps 2->0; assert stop during the second pass -> IDLE next clock, ch_rst_o=1, no seq_done_o.
REQ-042 ch_act_i held at 0 after trig -> seq_err_o=1 after exactly 16 clocks in WAIT_ACT, FSM in IDLE; next valid start clears seq_err_o.
REQ-043 Start with len=0, then with len=9 -> FSM stays in IDLE, seq_err_o=1; start and stop in the same cycle while busy -> IDLE.
REQ-044 Stored ncyc=0 -> ch_ncyc_o=1; dly=0 -> DLY lasts 1 clock; a table write on the same edge that enters LOAD -> the old value appears on ch_*; dac_rstn_i=0 during RUN -> IDLE with ch_rst_o=1 on the next edge.

Source files
------------

// File: rtl/red_pitaya_asg_seq_pkg.sv
// Shared types and defaults for the ASG segment sequencer.
package asg_seq_pkg;

  localparam int SEG_AW     = 14;  // segment address width stored in the table
  localparam int NSEG_DEF   = 8;
  localparam int ACT_TO_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT_ACT,
    S_RUN,
    S_DLY
  } state_t;

  typedef struct packed {
    logic [SEG_AW-1:0] ofs;
    logic [SEG_AW-1:0] size;
    logic [15:0]       ncyc;
    logic [31:0]       dly;
  } seg_t;

  // A zero cycle count would stall the channel; treat it as one cycle.
  function automatic logic [15:0] ncyc_eff(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_seq_tbl.sv
// Segment table: register file, one write port, one combinational read port.
module red_pitaya_asg_seq_tbl
  import asg_seq_pkg::*;
#(
  parameter  int NSEG = NSEG_DEF,
  localparam int AW   = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  seg_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output seg_t          rd_data
);

  seg_t tbl [NSEG];

  // Table storage; cleared on reset, written whenever the strobe is high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NSEG; i++) tbl[i] <= '0;
    end else if (we) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  assign rd_data = tbl[rd_addr];

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer: walks a table of buffer segments, programs the ASG
// channel for each one, fires a software trigger and waits out the burst.
module red_pitaya_asg_seq
  import asg_seq_pkg::*;
#(
  parameter  int RSZ    = SEG_AW,
  parameter  int NSEG   = NSEG_DEF,
  parameter  int ACT_TO = ACT_TO_DEF,
  localparam int AW     = $clog2(NSEG),
  localparam int TW     = $clog2(ACT_TO + 1)
) (
  input  logic            dac_clk_i,
  input  logic            dac_rstn_i,
  input  logic            seg_we_i,
  input  logic [AW-1:0]   seg_addr_i,
  input  logic [RSZ-1:0]  seg_ofs_i,
  input  logic [RSZ-1:0]  seg_size_i,
  input  logic [15:0]     seg_ncyc_i,
  input  logic [31:0]     seg_dly_i,
  input  logic            seq_start_i,
  input  logic            seq_stop_i,
  input  logic [AW:0]     seq_len_i,
  input  logic            seq_loop_i,
  input  logic            ch_act_i,
  output logic [RSZ+15:0] ch_ofs_o,
  output logic [RSZ+15:0] ch_size_o,
  output logic [15:0]     ch_ncyc_o,
  output logic            ch_rst_o,
  output logic            ch_trig_o,
  output logic            seq_busy_o,
  output logic [AW-1:0]   seq_seg_o,
  output logic            seq_done_o,
  output logic            seq_err_o
);

  state_t        state;
  logic [AW:0]   len_r;
  logic [31:0]   dly_r;
  logic [31:0]   dly_cnt;
  logic [TW-1:0] tmo;
  logic [AW-1:0] rd_idx;
  seg_t          wr_seg;
  seg_t          rd_seg;
  logic          len_ok, last_seg, abort, dly_end, go_load;

  assign wr_seg.ofs  = SEG_AW'(seg_ofs_i);
  assign wr_seg.size = SEG_AW'(seg_size_i);
  assign wr_seg.ncyc = seg_ncyc_i;
  assign wr_seg.dly  = seg_dly_i;

  red_pitaya_asg_seq_tbl #(.NSEG(NSEG)) u_tbl (
    .clk     (dac_clk_i),
    .rstn    (dac_rstn_i),
    .we      (seg_we_i),
    .wr_addr (seg_addr_i),
    .wr_data (wr_seg),
    .rd_addr (rd_idx),
    .rd_data (rd_seg)
  );

  assign len_ok   = (seq_len_i != '0) && (seq_len_i <= (AW+1)'(NSEG));
  assign last_seg = ((AW+1)'(seq_seg_o) + 1'b1) >= len_r;
  assign abort    = seq_stop_i && (state != S_IDLE);
  assign dly_end  = (state == S_DLY) && (dly_cnt <= 32'd1);
  assign go_load  = !abort &&
                    (((state == S_IDLE) && seq_start_i && len_ok) ||
                     (dly_end && (!last_seg || seq_loop_i)));

  // Read index is the segment about to be loaded, so the channel registers
  // see the table contents as they stand before the LOAD edge.
  always_comb begin
    rd_idx = seq_seg_o;
    if (state == S_IDLE || (state == S_DLY && last_seg)) rd_idx = '0;
    else if (state == S_DLY)                             rd_idx = seq_seg_o + 1'b1;
  end

  // Capture channel settings and the post-segment delay on entry to LOAD.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      ch_ofs_o  <= '0;
      ch_size_o <= '0;
      ch_ncyc_o <= '0;
      dly_r     <= '0;
    end else if (go_load) begin
      ch_ofs_o  <= {RSZ'(rd_seg.ofs), 16'h0};
      ch_size_o <= {RSZ'(rd_seg.size), 16'h0};
      ch_ncyc_o <= ncyc_eff(rd_seg.ncyc);
      dly_r     <= rd_seg.dly;
    end
  end

  // Sequencer FSM with registered status and channel control outputs.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state      <= S_IDLE;
      ch_rst_o   <= 1'b1;
      ch_trig_o  <= 1'b0;
      seq_busy_o <= 1'b0;
      seq_seg_o  <= '0;
      seq_done_o <= 1'b0;
      seq_err_o  <= 1'b0;
      len_r      <= '0;
      tmo        <= '0;
      dly_cnt    <= '0;
    end else begin
      ch_trig_o  <= 1'b0;
      seq_done_o <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        ch_rst_o   <= 1'b1;
        seq_busy_o <= 1'b0;
      end else if (go_load) begin
        state      <= S_LOAD;
        ch_rst_o   <= 1'b1;
        seq_busy_o <= 1'b1;
        seq_seg_o  <= rd_idx;
        if (state == S_IDLE) begin
          seq_err_o <= 1'b0;
          len_r     <= seq_len_i;
        end
      end else begin
        case (state)
          S_IDLE: if (seq_start_i) seq_err_o <= 1'b1;  // start with bad length
          S_LOAD: begin
            state     <= S_TRIG;
            ch_rst_o  <= 1'b0;
            ch_trig_o <= 1'b1;
          end
          S_TRIG: begin
            state <= S_WAIT_ACT;
            tmo   <= '0;
          end
          S_WAIT_ACT: begin
            if (ch_act_i) begin
              state <= S_RUN;
            end else if (tmo == TW'(ACT_TO - 1)) begin
              state      <= S_IDLE;
              seq_err_o  <= 1'b1;
              ch_rst_o   <= 1'b1;
              seq_busy_o <= 1'b0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_RUN: if (!ch_act_i) begin
            state   <= S_DLY;
            dly_cnt <= dly_r;
          end
          S_DLY: begin
            if (dly_end) begin  // last segment of a non-loop pass
              state      <= S_IDLE;
              seq_done_o <= 1'b1;
              ch_rst_o   <= 1'b1;
              seq_busy_o <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
